// File: rtl/seg7_decoder_rx.sv
// Seven-segment pattern receiver: debounces a sampled gfedcba pattern, decodes it to a hex
// digit and presents each new stable pattern once over a valid/ready handshake.
module seg7_decoder_rx #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [3:0]       out_value,
    output logic             out_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] CntMax = 4'(STABLE_CYCLES);

    typedef enum logic {StWait, StHold} state_e;

    state_e     state_q;
    logic [6:0] sample_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       rec_valid_q;
    logic [6:0] rec_q;

    logic       stable;
    logic       is_blank;
    logic       fresh;
    logic       emit;
    logic [3:0] dec_value;
    logic       dec_err;

    // When cnt_d reaches CntMax, seg_in equals sample_q, so sample_q is the stable pattern.
    always_comb begin
        cnt_d = 4'd0;
        if (seg_in == sample_q) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 4'd1;
        end
        stable   = (cnt_d == CntMax);
        is_blank = (sample_q == 7'b0000000);
        fresh    = !rec_valid_q || (sample_q != rec_q);
        emit     = (state_q == StWait) && stable && !is_blank && fresh;
    end

    always_comb begin
        dec_value = 4'h0;
        dec_err   = 1'b0;
        case (sample_q)
            7'b0111111: dec_value = 4'h0;
            7'b0000110: dec_value = 4'h1;
            7'b1011011: dec_value = 4'h2;
            7'b1001111: dec_value = 4'h3;
            7'b1100110: dec_value = 4'h4;
            7'b1101101: dec_value = 4'h5;
            7'b1111101: dec_value = 4'h6;
            7'b0000111: dec_value = 4'h7;
            7'b1111111: dec_value = 4'h8;
            7'b1101111: dec_value = 4'h9;
            7'b1110111: dec_value = 4'hA;
            7'b1111100: dec_value = 4'hB;
            7'b0111001: dec_value = 4'hC;
            7'b1011110: dec_value = 4'hD;
            7'b1111001: dec_value = 4'hE;
            7'b1110001: dec_value = 4'hF;
            default:    dec_err   = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StWait;
            sample_q    <= 7'b0000000;
            cnt_q       <= 4'd0;
            rec_valid_q <= 1'b0;
            rec_q       <= 7'b0000000;
            out_valid   <= 1'b0;
            out_value   <= 4'h0;
            out_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            sample_q <= seg_in;
            cnt_q    <= cnt_d;
            // A stable blank forgets the last digit so it can be shown again afterwards.
            if (stable && is_blank) begin
                rec_valid_q <= 1'b0;
            end
            case (state_q)
                StWait: begin
                    if (emit) begin
                        state_q     <= StHold;
                        out_valid   <= 1'b1;
                        out_value   <= dec_value;
                        out_err     <= dec_err;
                        rec_q       <= sample_q;
                        rec_valid_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q   <= StWait;
                        out_valid <= 1'b0;
                        if (out_err && (err_count != {ERR_W{1'b1}})) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
                default: state_q <= StWait;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_decoder_rx.sv
// Scoreboard bench for seg7_decoder_rx: a run-length reference model predicts each emission,
// a negedge monitor checks every presented item and the error counter against it.
module tb_seg7_decoder_rx;

    localparam int S  = 4;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg_in;
    logic          out_ready;
    logic          out_valid;
    logic [3:0]    out_value;
    logic          out_err;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    seg7_decoder_rx #(
        .STABLE_CYCLES(S),
        .ERR_W        (EW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_in   (seg_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_value(out_value),
        .out_err  (out_err),
        .err_count(err_count)
    );

    typedef struct packed {
        logic [3:0] value;
        logic       err;
    } item_t;

    logic [6:0] digits [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    int    total = 0;
    int    bad = 0;
    int    accepted = 0;
    item_t exp_q[$];

    // Reference model state
    logic [6:0] last_in = 7'b0;
    int         run = 1;
    bit         pend = 0;
    item_t      pend_item;
    bit         rec_v = 0;
    logic [6:0] rec = 7'b0;
    int         errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic item_t ref_decode(input logic [6:0] p);
        item_t it;
        it.value = 4'h0;
        it.err   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (digits[i] == p) begin
                it.value = 4'(i);
                it.err   = 1'b0;
            end
        end
        return it;
    endfunction

    // Model: a pattern is stable once seen on S+1 consecutive edges.
    initial begin
        bit stable;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                last_in = 7'b0;
                run     = 1;
                pend    = 0;
                rec_v   = 0;
                errs    = 0;
                exp_q.delete();
            end else begin
                if (seg_in == last_in) begin
                    run++;
                end else begin
                    run     = 1;
                    last_in = seg_in;
                end
                stable = (run >= S + 1);
                if (pend) begin
                    if (out_ready) begin
                        pend = 0;
                        if (pend_item.err && errs < (1 << EW) - 1) errs++;
                    end
                end else if (stable && seg_in != 7'b0 && (!rec_v || seg_in != rec)) begin
                    pend_item = ref_decode(seg_in);
                    exp_q.push_back(pend_item);
                    pend  = 1;
                    rec   = seg_in;
                    rec_v = 1;
                end
                if (stable && seg_in == 7'b0) rec_v = 0;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("valid", {31'b0, out_valid}, {31'b0, pend});
                chk("err_count", 32'(err_count), 32'(errs));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_item", 32'(out_valid), 32'd0);
                    end else begin
                        chk("value", 32'(out_value), 32'(exp_q[0].value));
                        chk("err", 32'(out_err), 32'(exp_q[0].err));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            accepted++;
                        end
                    end
                end
            end
        end
    end

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_value"}, 32'(out_value), 32'd0);
        chk({name, "_err"}, 32'(out_err), 32'd0);
        chk({name, "_errcnt"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        seg_in    = 7'b0;
        out_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;

        // Digit 2 held from edge 0: valid after edge 4 for exactly one cycle.
        seg_in = 7'b1011011;
        rst    = 1'b0;
        base   = accepted;
        repeat (4) @(posedge clk);
        #1;
        chk("lat_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_value", 32'(out_value), 32'd2);
        chk("lat_err", 32'(out_err), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_drop", 32'(out_valid), 32'd0);
        hold(7'b1011011, 12);
        chk("no_repeat", 32'(accepted - base), 32'd1);

        // 9, blank for 5 edges, 9 again: two emissions.
        base = accepted;
        hold(7'b1101111, 10);
        hold(7'b0000000, 5);
        hold(7'b1101111, 10);
        chk("blank_reemit", 32'(accepted - base), 32'd2);

        // Error pattern and counter saturation.
        hold(7'b0000000, 6);
        hold(7'b0000001, 8);
        chk("err_first", 32'(err_count), 32'd1);
        for (int i = 0; i < (1 << EW) + 3; i++) begin
            hold(7'b0000000, 6);
            hold(7'b0000001, 6);
        end
        chk("err_sat", 32'(err_count), 32'((1 << EW) - 1));

        // Back-pressure: 7 stays presented while F becomes stable.
        hold(7'b0000000, 6);
        out_ready = 1'b0;
        hold(7'b0000111, 8);
        hold(7'b1110001, 10);
        chk("bp_hold_value", 32'(out_value), 32'd7);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_accept", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_value", 32'(out_value), 32'hF);
        hold(7'b1110001, 4);

        // Toggle every 2 edges: never stable.
        base = accepted;
        for (int i = 0; i < 20; i++) begin
            hold((i % 2) ? 7'b1111111 : 7'b0111111, 2);
        end
        chk("glitch_none", 32'(accepted - base), 32'd0);

        // Reset during HOLD, then re-emission 4 edges after release.
        hold(7'b0000000, 6);
        out_ready = 1'b0;
        hold(7'b1011011, 8);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midhold_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_reemit_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_reemit_valid", 32'(out_valid), 32'd1);
        chk("rst_reemit_value", 32'(out_value), 32'd2);
        out_ready = 1'b1;
        hold(7'b1011011, 3);

        // Randomized segments with random back-pressure.
        for (int k = 0; k < 250; k++) begin
            logic [6:0] p;
            int         len;
            int         kind;
            kind = int'($urandom % 8);
            if (kind == 0)      p = 7'b0;
            else if (kind == 1) p = 7'($urandom);
            else                p = digits[$urandom % 16];
            len = int'($urandom_range(1, 9));
            for (int c = 0; c < len; c++) begin
                seg_in    = p;
                out_ready = ($urandom % 4) != 0;
                @(posedge clk);
                #1;
            end
        end

        out_ready = 1'b1;
        hold(7'b0000000, 4);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_decoder_rx.md
SEG7_DECODER_RX -- requirements
Module: seg7_decoder_rx

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 1..15: consecutive clock edges a new segment pattern must hold, after first capture, before it is decoded.
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 seg_in  input  7  segment pattern in gfedcba order (bit6=g … bit0=a), 1 = segment lit.
REQ-006 out_ready  input  1  consumer accepts out_value/out_err this cycle.
REQ-007 out_valid  output  1  decoded digit pending.
REQ-008 out_value  output  4  decoded hex digit 0..F.
REQ-009 out_err  output  1  pending item is an unrecognised pattern.
REQ-010 err_count  output  ERR_W  saturating count of accepted error items.

Function
REQ-011 The block shall register seg_in into a sample register on every edge; all decisions use the registered sample.
REQ-012 The block shall keep a stability counter that clears to 0 when the new sample differs from the previous sample, and otherwise increments, saturating at STABLE_CYCLES.
REQ-013 Decode table: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-014 Pattern 0000000 (blank) shall never be emitted, and on reaching stability it shall clear the last-emitted record.
REQ-015 Any other pattern not in REQ-013 shall be emitted with out_err=1 and out_value=0.
REQ-016 FSM states: WAIT (no item pending) and HOLD (out_valid=1).
REQ-017 WAIT->HOLD shall occur on the edge where the counter reaches STABLE_CYCLES, the sample is non-blank, and the sample differs from the last-emitted record or the record is empty; on that edge out_value/out_err load and the record updates.
REQ-018 HOLD->WAIT shall occur on any edge with out_ready=1; out_valid drops the following cycle.
REQ-019 In HOLD, out_value and out_err shall remain constant regardless of seg_in.
REQ-020 Patterns that become stable during HOLD shall be dropped, and the record shall not update.
REQ-021 After HOLD->WAIT, a sample that is still stable and differs from the record shall be emitted on the next edge, with no re-count.
REQ-022 A held pattern shall be emitted once only; the same digit is emitted again only after an intervening different stable pattern or blank.
REQ-023 err_count shall increment on each handshake (out_valid and out_ready both 1) with out_err=1, and hold at all-ones.
REQ-024 Latency: a pattern first present before edge k and held shall raise out_valid after edge k+STABLE_CYCLES when the block is in WAIT.
REQ-025 A glitch shorter than STABLE_CYCLES+1 edges shall produce no output and shall restart counting.

Reset
REQ-026 rst=1 shall immediately force out_valid=0, out_value=0, out_err=0, err_count=0, sample=0000000, counter=0, record empty and state WAIT, including mid-HOLD; pending data is discarded.
REQ-027 After rst deasserts, an input already stable shall be treated as a new pattern, following the REQ-024 latency from the first post-reset edge.

Verification
REQ-028 STABLE_CYCLES=4, out_ready=1, seg_in=1011011 held from edge 0 -> out_valid=1, out_value=2, out_err=0 after edge 4 for exactly one cycle, with no repeat while held.
REQ-029 seg_in 1101111 held, then 0000000 held 5 edges, then 1101111 again -> two emissions of value 9 and none for the blank.
REQ-030 seg_in=0000001 held, out_ready=1 -> out_err=1, out_value=0, err_count goes 0->1; 2^ERR_W+3 further distinct error episodes -> err_count stays all-ones.
REQ-031 out_ready=0, emit 7 (0000111), then present stable F (1110001) -> out_value stays 7; raising out_ready -> F emitted on the edge after the 7 is accepted.
REQ-032 seg_in toggles between 0111111 and 1111111 every 2 edges -> out_valid never asserts.
REQ-033 rst pulsed while out_valid=1 -> all outputs 0 asynchronously; the held pattern is re-emitted 4 edges after release.
